// File: rtl/result_reporter.sv
// Post-halt self-check reporter: snapshots the cycle count and pass/fail flags on the
// halt edge, then streams "<flags> <8 hex digits>" into the OLED character buffer.
module result_reporter #(
  parameter int          CHECK_N   = 4,
  parameter logic [5:0]  BASE_ADDR = 6'd0
) (
  input  logic               sysclk,
  input  logic               cpu_reset,
  input  logic               halt,
  input  logic [CHECK_N-1:0] pass,
  input  logic [31:0]        cycle_count,
  input  logic               disp_ready,
  output logic               we,
  output logic [5:0]         write_addr,
  output logic [7:0]         write_data,
  output logic               busy,
  output logic               done
);

  localparam int         LEN  = CHECK_N + 9;
  localparam logic [4:0] LAST = 5'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [4:0]         index, index_nx;
  logic               halt_q;
  logic               halt_edge;
  logic [CHECK_N-1:0] pass_q;
  logic [31:0]        count_q;
  logic               flag;
  logic [3:0]         nibble;
  logic [7:0]         ascii;

  assign halt_edge = halt & ~halt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears the snapshots along with the FSM.
  always_ff @(posedge sysclk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state   <= IDLE;
      index   <= '0;
      halt_q  <= 1'b0;
      pass_q  <= '0;
      count_q <= '0;
    end else begin
      state  <= state_nx;
      index  <= index_nx;
      halt_q <= halt;
      // Inputs are captured on the accepted halt edge; nothing later can disturb them.
      if (state == IDLE && halt_edge) begin
        pass_q  <= pass;
        count_q <= cycle_count;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    index_nx = index;
    unique case (state)
      IDLE: if (halt_edge) state_nx = SNAP;
      SNAP: begin
        index_nx = '0;
        state_nx = EMIT;
      end
      EMIT: begin
        if (disp_ready) begin
          if (index == LAST) begin
            state_nx = DONE;
            index_nx = '0;
          end else begin
            index_nx = index + 5'd1;
          end
        end
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Character selection: flags (MSB first), a space, then the count in uppercase hex.
  always_comb begin
    flag   = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < CHECK_N; i++)
      if (index == 5'(i)) flag = pass_q[CHECK_N-1-i];
    for (int k = 0; k < 8; k++)
      if (index == 5'(CHECK_N + 1 + k)) nibble = count_q[(7-k)*4 +: 4];

    if (index < 5'(CHECK_N))
      ascii = flag ? 8'h2B : 8'h2D;
    else if (index == 5'(CHECK_N))
      ascii = 8'h20;
    else if (nibble < 4'd10)
      ascii = 8'h30 + {4'h0, nibble};
    else
      ascii = 8'h37 + {4'h0, nibble};
  end

  assign we         = (state == EMIT);
  assign busy       = (state == SNAP) || (state == EMIT);
  assign done       = (state == DONE);
  assign write_addr = BASE_ADDR + {1'b0, index};
  assign write_data = we ? ascii : 8'h00;

endmodule

// File: tb/tb_result_reporter.sv
// Self-checking bench for result_reporter: randomized halt reports compared against a
// string-based model of the expected ASCII line, with stalls, wraps and re-halts.
module tb_result_reporter;

  localparam int N = 4;
  localparam int L = N + 9;

  logic         sysclk = 1'b0;
  logic         cpu_reset;
  logic         halt;
  logic [N-1:0] pass;
  logic [31:0]  cycle_count;
  logic         disp_ready;

  logic         we0, busy0, done0;
  logic [5:0]   addr0;
  logic [7:0]   data0;
  logic         we1, busy1, done1;
  logic [5:0]   addr1;
  logic [7:0]   data1;

  int errors = 0;
  int checks = 0;

  logic [5:0] a0_q[$];
  logic [7:0] d0_q[$];
  logic [5:0] a1_q[$];
  logic [7:0] d1_q[$];
  int         first_we, done_cycle, hold_err;
  bit         busy_snap;

  result_reporter #(.CHECK_N(N), .BASE_ADDR(6'd0)) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .halt(halt), .pass(pass),
    .cycle_count(cycle_count), .disp_ready(disp_ready), .we(we0),
    .write_addr(addr0), .write_data(data0), .busy(busy0), .done(done0)
  );

  result_reporter #(.CHECK_N(N), .BASE_ADDR(6'd62)) dut62 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .halt(halt), .pass(pass),
    .cycle_count(cycle_count), .disp_ready(disp_ready), .we(we1),
    .write_addr(addr1), .write_data(data1), .busy(busy1), .done(done1)
  );

  always #5 sysclk = ~sysclk;

  // Reference line: '+'/'-' per flag from the top bit down, a space, 8 uppercase hex digits.
  function automatic string exp_line(input logic [N-1:0] p, input logic [31:0] c);
    string s;
    s = "";
    for (int i = N - 1; i >= 0; i--) begin
      if (p[i]) s = {s, "+"};
      else      s = {s, "-"};
    end
    s = {s, " ", $sformatf("%08h", c)};
    return s.toupper();
  endfunction

  task automatic do_reset();
    @(posedge sysclk); #1;
    cpu_reset = 1'b1;
    halt      = 1'b0;
    @(posedge sysclk); #1;
    cpu_reset = 1'b0;
  endtask

  task automatic pulse_halt(input logic [N-1:0] p, input logic [31:0] c);
    @(posedge sysclk); #1;
    pass        = p;
    cycle_count = c;
    halt        = 1'b1;
    @(posedge sysclk); #1;
    halt = 1'b0;
  endtask

  // Observe one report: cycle 0 is the SNAP cycle; writes are logged when accepted.
  task automatic collect(input int stall_at, input bit rand_stall,
                         input bit change_inputs, input int rehalt_at);
    int         stall_left = 0;
    bit         stalled    = 0;
    bit         held_valid = 0;
    logic [5:0] held_a     = '0;
    logic [7:0] held_d     = '0;
    a0_q.delete(); d0_q.delete(); a1_q.delete(); d1_q.delete();
    first_we = -1; done_cycle = -1; hold_err = 0; busy_snap = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge sysclk);
      if (cyc == 0) busy_snap = busy0 && !we0;
      if (done0) begin
        done_cycle = cyc;
        break;
      end
      if (we0 && first_we < 0) first_we = cyc;
      if (held_valid && (we0 !== 1'b1 || addr0 !== held_a || data0 !== held_d)) hold_err++;
      held_valid = 0;
      if (we0) begin
        if (disp_ready) begin
          a0_q.push_back(addr0);
          d0_q.push_back(data0);
        end else begin
          held_valid = 1;
          held_a     = addr0;
          held_d     = data0;
        end
      end
      if (we1 && disp_ready) begin
        a1_q.push_back(addr1);
        d1_q.push_back(data1);
      end
      @(posedge sysclk); #1;
      halt = (cyc == rehalt_at);
      if (change_inputs && we0) begin
        pass        = N'($urandom);
        cycle_count = $urandom;
      end
      if (!stalled && stall_at >= 0 && we0 && addr0 == 6'(stall_at)) begin
        stalled    = 1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        disp_ready = 1'b0;
        stall_left--;
      end else begin
        disp_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    if (done_cycle < 0) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout: done not seen within 200 cycles");
    end
    halt       = 1'b0;
    disp_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (we0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== 6'd0 || data0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: we=%b busy=%b done=%b addr=%0d data=%h, need 0 0 0 0 00",
               we0, busy0, done0, addr0, data0);
    end
    checks++;
    if (addr1 !== 6'd62 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_base62: addr=%0d busy=%b, need 62 0", addr1, busy1);
    end
    @(posedge sysclk); #1;
    cpu_reset = 1'b0;
    pulse_halt(4'b1010, 32'hDEADBEEF);
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    cpu_reset = 1'b1;
    #1;
    checks++;
    if (we0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== 6'd0 || data0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_emit: we=%b busy=%b done=%b addr=%0d data=%h, need 0 0 0 0 00",
               we0, busy0, done0, addr0, data0);
    end
    @(posedge sysclk); #1;
    cpu_reset = 1'b0;
  endtask

  task automatic test_all_pass();
    string s;
    do_reset();
    s = exp_line(4'b1111, 32'h00001A2F);
    pulse_halt(4'b1111, 32'h00001A2F);
    collect(-1, 0, 0, -1);
    checks++;
    if (s != "++++ 00001A2F") begin
      errors++;
      $display("FAIL model_line: got '%s' need '++++ 00001A2F'", s);
    end
    checks++;
    if (a0_q.size() != L) begin
      errors++;
      $display("FAIL all_pass_count: got %0d writes need %0d", a0_q.size(), L);
    end
    for (int i = 0; i < a0_q.size() && i < L; i++) begin
      checks++;
      if (a0_q[i] !== 6'(i) || d0_q[i] !== 8'(s[i])) begin
        errors++;
        $display("FAIL all_pass_char%0d: got addr %0d data %h need addr %0d data %h",
                 i, a0_q[i], d0_q[i], i, 8'(s[i]));
      end
    end
    checks++;
    if (!busy_snap || first_we != 1 || done_cycle != L + 1) begin
      errors++;
      $display("FAIL all_pass_latency: snap_busy=%b first_we=%0d done=%0d need 1 1 %0d",
               busy_snap, first_we, done_cycle, L + 1);
    end
  endtask

  task automatic test_mixed_flags();
    string      s;
    logic [N-1:0] p;
    logic [31:0]  c;
    do_reset();
    pulse_halt(4'b0101, 32'h0);
    collect(-1, 0, 0, -1);
    checks++;
    if (d0_q.size() < 4 || d0_q[0] !== 8'h2D || d0_q[1] !== 8'h2B || d0_q[2] !== 8'h2D || d0_q[3] !== 8'h2B) begin
      errors++;
      $display("FAIL flags_0101: got %0d writes, first chars %h %h %h %h need 2D 2B 2D 2B",
               d0_q.size(), d0_q[0], d0_q[1], d0_q[2], d0_q[3]);
    end
    for (int t = 0; t < 4; t++) begin
      p = N'($urandom);
      c = $urandom;
      s = exp_line(p, c);
      do_reset();
      pulse_halt(p, c);
      collect(-1, 1, 1, -1);
      checks++;
      if (d0_q.size() != L) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d writes need %0d", t, d0_q.size(), L);
      end
      for (int i = 0; i < d0_q.size() && i < L; i++) begin
        checks++;
        if (a0_q[i] !== 6'(i) || d0_q[i] !== 8'(s[i])) begin
          errors++;
          $display("FAIL rand%0d_char%0d: got addr %0d data %h need addr %0d data %h",
                   t, i, a0_q[i], d0_q[i], i, 8'(s[i]));
        end
      end
      checks++;
      if (hold_err != 0) begin
        errors++;
        $display("FAIL rand%0d_hold: %0d stalled cycles changed outputs, need 0", t, hold_err);
      end
    end
  endtask

  task automatic test_stall();
    string s;
    do_reset();
    s = exp_line(4'b1111, 32'h00001A2F);
    pulse_halt(4'b1111, 32'h00001A2F);
    collect(5, 0, 1, -1);
    checks++;
    if (a0_q.size() != L || hold_err != 0 || done_cycle != L + 4) begin
      errors++;
      $display("FAIL stall_shape: writes=%0d hold_err=%0d done=%0d need %0d 0 %0d",
               a0_q.size(), hold_err, done_cycle, L, L + 4);
    end
    for (int i = 0; i < a0_q.size() && i < L; i++) begin
      checks++;
      if (a0_q[i] !== 6'(i) || d0_q[i] !== 8'(s[i])) begin
        errors++;
        $display("FAIL stall_char%0d: got addr %0d data %h need addr %0d data %h",
                 i, a0_q[i], d0_q[i], i, 8'(s[i]));
      end
    end
  endtask

  task automatic test_base_wrap();
    string s;
    do_reset();
    s = exp_line(4'b1111, 32'h00001A2F);
    pulse_halt(4'b1111, 32'h00001A2F);
    collect(-1, 0, 0, -1);
    checks++;
    if (a1_q.size() != L || done1 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes done=%b need %0d 1", a1_q.size(), done1, L);
    end
    for (int i = 0; i < a1_q.size() && i < L; i++) begin
      checks++;
      if (a1_q[i] !== 6'((62 + i) % 64) || d1_q[i] !== 8'(s[i])) begin
        errors++;
        $display("FAIL wrap_char%0d: got addr %0d data %h need addr %0d data %h",
                 i, a1_q[i], d1_q[i], (62 + i) % 64, 8'(s[i]));
      end
    end
  endtask

  task automatic test_ignored_halt();
    string s;
    int    bad;
    do_reset();
    s = exp_line(4'b0011, 32'hCAFE0042);
    pulse_halt(4'b0011, 32'hCAFE0042);
    collect(-1, 0, 0, 5);
    checks++;
    if (a0_q.size() != L || done_cycle != L + 1) begin
      errors++;
      $display("FAIL rehalt_emit: writes=%0d done=%0d need %0d %0d", a0_q.size(), done_cycle, L, L + 1);
    end
    pulse_halt(4'b1111, 32'hFFFFFFFF);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (we0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rehalt_done: %0d cycles left DONE, need 0", bad);
    end
  endtask

  task automatic test_reissue();
    string s;
    s = exp_line(4'b1001, 32'h89ABCDEF);
    @(posedge sysclk); #1;
    cpu_reset   = 1'b1;
    halt        = 1'b1;
    pass        = 4'b1001;
    cycle_count = 32'h89ABCDEF;
    @(posedge sysclk); #1;
    cpu_reset = 1'b0;
    @(posedge sysclk); #1;
    halt = 1'b0;
    collect(-1, 0, 0, -1);
    checks++;
    if (a0_q.size() != L || done_cycle != L + 1) begin
      errors++;
      $display("FAIL reissue_count: writes=%0d done=%0d need %0d %0d", a0_q.size(), done_cycle, L, L + 1);
    end
    for (int i = 0; i < a0_q.size() && i < L; i++) begin
      checks++;
      if (a0_q[i] !== 6'(i) || d0_q[i] !== 8'(s[i])) begin
        errors++;
        $display("FAIL reissue_char%0d: got addr %0d data %h need addr %0d data %h",
                 i, a0_q[i], d0_q[i], i, 8'(s[i]));
      end
    end
  endtask

  initial begin
    cpu_reset   = 1'b1;
    halt        = 1'b0;
    pass        = '0;
    cycle_count = '0;
    disp_ready  = 1'b1;
    #2;
    test_reset();
    test_all_pass();
    test_mixed_flags();
    test_stall();
    test_base_wrap();
    test_ignored_halt();
    test_reissue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
